// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in parallel-out shift register (in: din, clk, reset; out: dout, word_valid, bit_count); define SIPO_SHIFT_RIGHT_EN to shift din in at the MSB
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic                       din,
  input  logic                       clk,
  input  logic                       reset,
  output logic [WIDTH-1:0]           dout,
  output logic                       word_valid,
  output logic [$clog2(WIDTH):0]     bit_count
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] shifted;
  logic last;
`ifdef SIPO_SHIFT_RIGHT_EN
  assign shifted = {din, dout[WIDTH-1:1]};
`else
  assign shifted = {dout[WIDTH-2:0], din};
`endif
  assign last = bit_count == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      word_valid <= 1'b0;
      bit_count  <= '0;
    end else begin
      dout       <= shifted;
      word_valid <= last;
      bit_count  <= last ? '0 : bit_count + CW'(1);
    end
  end
endmodule

// File: tb/tb_sipo_shift_reg.sv
// tb_sipo_shift_reg: directed checks of sipo_shift_reg at WIDTH=4
module tb_sipo_shift_reg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic [3:0] dout;
  logic word_valid;
  logic [2:0] bit_count;
  int checks = 0;
  int passed = 0;

  sipo_shift_reg #(.WIDTH(4)) dut (
    .din(din), .clk(clk), .reset(reset),
    .dout(dout), .word_valid(word_valid), .bit_count(bit_count)
  );

  always #10 clk = ~clk;

  task automatic tick(input logic r, input logic d);
    @(negedge clk);
    reset = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0);
    checks++; if (dout !== 4'b0000) $display("FAIL reset dout got %b want 0000", dout); else passed++;
    checks++; if (word_valid !== 1'b0) $display("FAIL reset word_valid got %b want 0", word_valid); else passed++;
    checks++; if (bit_count !== 3'd0) $display("FAIL reset bit_count got %0d want 0", bit_count); else passed++;
  endtask

  task automatic test_shift_pattern();
    logic       di [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`ifdef SIPO_SHIFT_RIGHT_EN
    logic [3:0] ed [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1010};
`else
    logic [3:0] ed [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0101};
`endif
    logic       ev [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic [2:0] ec [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, di[i]);
      checks++; if (dout !== ed[i]) $display("FAIL shift[%0d] dout got %b want %b", i, dout, ed[i]); else passed++;
      checks++; if (word_valid !== ev[i]) $display("FAIL shift[%0d] word_valid got %b want %b", i, word_valid, ev[i]); else passed++;
      checks++; if (bit_count !== ec[i]) $display("FAIL shift[%0d] bit_count got %0d want %0d", i, bit_count, ec[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid_word();
    logic       di [4] = '{1, 0, 1, 1};
`ifdef SIPO_SHIFT_RIGHT_EN
    logic [3:0] part = 4'b1100;
    logic [3:0] ed [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
`else
    logic [3:0] part = 4'b0011;
    logic [3:0] ed [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
`endif
    logic       ev [4] = '{0, 0, 0, 1};
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    checks++; if (dout !== part) $display("FAIL midword partial dout got %b want %b", dout, part); else passed++;
    checks++; if (bit_count !== 3'd2) $display("FAIL midword partial bit_count got %0d want 2", bit_count); else passed++;
    tick(1'b1, 1'b1);
    checks++; if (dout !== 4'b0000) $display("FAIL midword reset dout got %b want 0000", dout); else passed++;
    checks++; if (bit_count !== 3'd0) $display("FAIL midword reset bit_count got %0d want 0", bit_count); else passed++;
    checks++; if (word_valid !== 1'b0) $display("FAIL midword reset word_valid got %b want 0", word_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, di[i]);
      checks++; if (dout !== ed[i]) $display("FAIL midword[%0d] dout got %b want %b", i, dout, ed[i]); else passed++;
      checks++; if (word_valid !== ev[i]) $display("FAIL midword[%0d] word_valid got %b want %b", i, word_valid, ev[i]); else passed++;
    end
  endtask

  task automatic test_single_one();
    logic       di [4] = '{1, 0, 0, 0};
`ifdef SIPO_SHIFT_RIGHT_EN
    logic [3:0] ed [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
`else
    logic [3:0] ed [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    logic       ev [4] = '{0, 0, 0, 1};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, di[i]);
      checks++; if (dout !== ed[i]) $display("FAIL walk[%0d] dout got %b want %b", i, dout, ed[i]); else passed++;
      checks++; if (word_valid !== ev[i]) $display("FAIL walk[%0d] word_valid got %b want %b", i, word_valid, ev[i]); else passed++;
    end
  endtask

  task automatic test_reset_priority();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    checks++; if (word_valid !== 1'b1) $display("FAIL prio setup word_valid got %b want 1", word_valid); else passed++;
    checks++; if (dout !== 4'b1111) $display("FAIL prio setup dout got %b want 1111", dout); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      checks++; if (dout !== 4'b0000) $display("FAIL prio[%0d] dout got %b want 0000", i, dout); else passed++;
      checks++; if (word_valid !== 1'b0) $display("FAIL prio[%0d] word_valid got %b want 0", i, word_valid); else passed++;
      checks++; if (bit_count !== 3'd0) $display("FAIL prio[%0d] bit_count got %0d want 0", i, bit_count); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_shift_pattern();
    test_reset_mid_word();
    test_single_one();
    test_reset_priority();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
